// File: rtl/panel_frame_sequencer_if.sv
// Gate-driver / readout side of the panel frame sequencer: row address, gate,
// panel reset and the per-row req/ack handshake with the ADC readout path.
interface panel_frame_sequencer_if #(
    parameter int ROW_W = 12
);
    logic [ROW_W-1:0] row_addr;
    logic             row_gate_on;
    logic             panel_reset;
    logic             row_req;
    logic             row_ack;

    modport master (
        output row_addr,
        output row_gate_on,
        output panel_reset,
        output row_req,
        input  row_ack
    );

    modport slave (
        input  row_addr,
        input  row_gate_on,
        input  panel_reset,
        input  row_req,
        output row_ack
    );
endinterface

// File: rtl/panel_frame_sequencer.sv
// TFT panel frame sequencer: reset, integration, row gate/readout sweep and idle dummy scans.
// Optional macro FRAME_SEQ_TIMEOUT_EN bounds the row_ack wait to ACK_TIMEOUT cycles.
module panel_frame_sequencer #(
    parameter int ROW_W       = 12,
    parameter int TIME_W      = 16,
    parameter int TICK_DIV    = 100,
    parameter int RESET_CYC   = 64,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle_mode,
    input  logic              frame_start,
    input  logic              frame_reset,
    input  logic [TIME_W-1:0] integration_time,
    input  logic [TIME_W-1:0] dummy_period,
    input  logic              dummy_enable,
    input  logic [ROW_W-1:0]  row_start,
    input  logic [ROW_W-1:0]  row_end,
    input  logic [7:0]        row_clk_div,
    panel_frame_sequencer_if.master rdo,
    output logic              frame_busy,
    output logic              dummy_busy,
    output logic              frame_done,
    output logic              frame_error
);
    localparam int CYC_MAX0 = (RESET_CYC > 256) ? RESET_CYC : 256;
    localparam int CYC_MAX  = (ACK_TIMEOUT > CYC_MAX0) ? ACK_TIMEOUT : CYC_MAX0;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_INTEG, S_GATE, S_READ, S_DONE, S_DUMMY
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_addr_q, row_addr_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TIME_W-1:0] tick_q, tick_d;
    logic              err_q, err_d;

    logic [7:0]        div_eff;
    logic              row_last_cyc;
    logic              pre_wrap;
    logic              dummy_run;

    always_comb begin
        div_eff      = (row_clk_div == 8'd0) ? 8'd1 : row_clk_div;
        row_last_cyc = (cyc_q == CYC_W'(div_eff - 8'd1));
        pre_wrap     = (pre_q == PRE_W'(TICK_DIV - 1));
        dummy_run    = dummy_enable && (dummy_period != '0) && !idle_mode;
    end

    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        cyc_d      = cyc_q;
        pre_d      = pre_q;
        tick_d     = tick_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                // A frame request always wins over a coincident dummy expiry.
                if (frame_start && !idle_mode) begin
                    pre_d  = '0;
                    tick_d = '0;
                    if (row_start <= row_end) begin
                        state_d    = S_RESET;
                        row_addr_d = row_start;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (dummy_run) begin
                    if (pre_wrap) begin
                        pre_d = '0;
                        if (tick_q == dummy_period - TIME_W'(1)) begin
                            tick_d = '0;
                            if (row_start <= row_end) begin
                                state_d    = S_DUMMY;
                                row_addr_d = row_start;
                            end
                        end else begin
                            tick_d = tick_q + TIME_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end else begin
                    pre_d  = '0;
                    tick_d = '0;
                end
            end
            S_RESET: begin
                if (cyc_q == CYC_W'(RESET_CYC - 1)) begin
                    cyc_d   = '0;
                    pre_d   = '0;
                    tick_d  = '0;
                    state_d = (integration_time == '0) ? S_GATE : S_INTEG;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_INTEG: begin
                if (pre_wrap) begin
                    pre_d = '0;
                    if (tick_q == integration_time - TIME_W'(1)) begin
                        tick_d  = '0;
                        state_d = S_GATE;
                    end else begin
                        tick_d = tick_q + TIME_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            S_GATE: begin
                if (row_last_cyc) begin
                    cyc_d   = '0;
                    state_d = S_READ;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_READ: begin
                if (rdo.row_ack) begin
                    cyc_d = '0;
                    if (row_addr_q == row_end) begin
                        state_d = S_DONE;
                    end else begin
                        row_addr_d = row_addr_q + ROW_W'(1);
                        state_d    = S_GATE;
                    end
                end
`ifdef FRAME_SEQ_TIMEOUT_EN
                else if (cyc_q == CYC_W'(ACK_TIMEOUT - 1)) begin
                    cyc_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DUMMY: begin
                if (row_last_cyc) begin
                    cyc_d = '0;
                    if (row_addr_q == row_end) begin
                        state_d = S_IDLE;
                    end else begin
                        row_addr_d = row_addr_q + ROW_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_reset) begin
            state_d    = S_IDLE;
            row_addr_d = '0;
            cyc_d      = '0;
            pre_d      = '0;
            tick_d     = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_addr_q <= '0;
            cyc_q      <= '0;
            pre_q      <= '0;
            tick_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_addr_q <= row_addr_d;
            cyc_q      <= cyc_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign rdo.row_addr    = row_addr_q;
    assign rdo.row_gate_on = (state_q == S_GATE) || (state_q == S_DUMMY);
    assign rdo.panel_reset = (state_q == S_RESET) || (state_q == S_DUMMY);
    assign rdo.row_req     = (state_q == S_READ);
    assign frame_busy      = (state_q != S_IDLE) && (state_q != S_DUMMY);
    assign dummy_busy      = (state_q == S_DUMMY);
    assign frame_done      = (state_q == S_DONE);
    assign frame_error     = err_q;
endmodule
